t_intersection_phase_scheduler: RTL and testbench
=================================================

Name: t_intersection_phase_scheduler

Overview:
Timing and request-arbitration core for the T-intersection. It decides when the right of way passes between the main road and the side road. Inputs are the side-road vehicle sensor and the pedestrian button (crossing the main road). It drives the six lamp outputs plus walk/don't-walk, and enforces min/max green, yellow and all-red clearance intervals from a tick prescaler.

Parameters:
TICK_DIV, 50000000, clk cycles per timing tick (1 s at 50 MHz)
MAIN_MIN, 20, minimum main green, ticks
SIDE_MIN, 5, minimum side green, ticks
SIDE_MAX, 15, maximum side green, ticks (SIDE_MIN <= SIDE_MAX)
YELLOW, 3, yellow interval, ticks (both roads)
ALL_RED, 1, all-red clearance, ticks
PED_WALK, 7, walk interval, ticks (PED_WALK <= SIDE_MAX)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
side_sensor  input  1  side-road vehicle present, level, synchronous to clk
ped_button  input  1  pedestrian request, level or pulse, synchronous to clk
main_red / main_yellow / main_green  output  1 each  main-road lamps, registered
side_red / side_yellow / side_green  output  1 each  side-road lamps, registered
ped_walk  output  1  walk lamp for the main-road crossing, registered
ped_dont_walk  output  1  always the inverse of ped_walk
phase  output  3  encoded state: 0 MAIN_GREEN, 1 MAIN_YELLOW, 2 ALL_RED_A, 3 SIDE_GREEN, 4 SIDE_YELLOW, 5 ALL_RED_B

Behaviour:
- Reset, asynchronous on reset_n low:
  - State goes to MAIN_GREEN. main_green=1, side_red=1, ped_dont_walk=1; all other outputs 0; phase=0.
  - Prescaler, tick timer and both request latches are cleared.
- Prescaler: counts 0..TICK_DIV-1. tick is a one-cycle pulse when the count equals TICK_DIV-1. The prescaler is cleared on every state entry, so a state of N ticks lasts exactly N*TICK_DIV cycles.
- Tick timer: counts ticks within the current state and clears on state entry. Its width is sized for the largest timing parameter.
- Transitions are evaluated only on tick; "timer reaches N" means timer==N-1 with tick high.
- MAIN_GREEN -> MAIN_YELLOW: on a tick with timer >= MAIN_MIN-1 and (side_pend or ped_pend). With no requests, main green holds indefinitely.
- MAIN_YELLOW -> ALL_RED_A: after YELLOW ticks.
- ALL_RED_A -> SIDE_GREEN: after ALL_RED ticks.
  - On this edge, walk_grant := ped_pend; side_pend and ped_pend clear.
- SIDE_GREEN -> SIDE_YELLOW, on the tick where timer reaches T:
  - T_min = max(SIDE_MIN, walk_grant ? PED_WALK : 0).
  - Exit at T_min if side_sensor is low on that tick. Otherwise extend one tick at a time while side_sensor stays high.
  - Unconditional exit at SIDE_MAX.
- SIDE_YELLOW -> ALL_RED_B: after YELLOW ticks. ALL_RED_B -> MAIN_GREEN: after ALL_RED ticks.
- Lamps per state:
  - MAIN_GREEN: main green, side red.
  - MAIN_YELLOW: main yellow, side red.
  - ALL_RED_A / ALL_RED_B: both red.
  - SIDE_GREEN: main red, side green.
  - SIDE_YELLOW: main red, side yellow.
  - Exactly one lamp per road is lit at all times.
- Lamp outputs update on the same edge as the state register; there is no extra latency.
- ped_walk: high during the first PED_WALK ticks of SIDE_GREEN when walk_grant=1, and low in every other state.
- side_pend: set on any cycle with side_sensor high, except while in SIDE_GREEN. Sensor activity in SIDE_GREEN only extends that green and does not queue another cycle.
- ped_pend: set on any cycle with ped_button high, in any state.
  - A press during SIDE_GREEN stays pending and is served on the next cycle.
  - A press coinciding with the clearing edge into SIDE_GREEN is not lost; set wins over clear.
- Conflict safety: main_green/main_yellow and side_green/side_yellow are never high simultaneously. Reaching an unused phase code forces MAIN_YELLOW.
- Reset mid-phase: immediate return to the reset values above; pending requests are discarded.

Test Plan:
All scenarios use TICK_DIV=4, MAIN_MIN=4, SIDE_MIN=3, SIDE_MAX=6, YELLOW=2, ALL_RED=1, PED_WALK=5.
1. Reset deasserted, no requests for 200 cycles -> phase stays 0, main_green=1, side_red=1, ped_dont_walk=1 throughout.
2. One-cycle side_sensor pulse at cycle 2 after reset -> MAIN_GREEN lasts 16 cycles, MAIN_YELLOW 8, ALL_RED_A 4, SIDE_GREEN 12, SIDE_YELLOW 8, ALL_RED_B 4, then phase=0 with no further cycle.
3. side_sensor held high continuously -> SIDE_GREEN lasts 24 cycles (SIDE_MAX); no back-to-back side cycle is queued; main green afterwards lasts at least 16 cycles.
4. ped_button pulse with no vehicle -> SIDE_GREEN lasts 20 cycles (PED_WALK dominates SIDE_MIN); ped_walk high for exactly those 20 cycles; ped_dont_walk is its inverse.
5. ped_button pressed mid-SIDE_GREEN -> current walk unaffected; a second full side cycle with ped_walk follows after MAIN_MIN.
6. reset_n pulsed low during MAIN_YELLOW with ped_pend set -> outputs asynchronously return to reset values; after release, main green holds indefinitely because the request was discarded.

Source files
------------

// File: rtl/t_intersection_phase_scheduler.sv
// Right-of-way sequencer for a T-junction: main/side green, yellow and all-red clearance from a tick prescaler.
// Lamp and walk outputs are registered and change on the same edge as the phase register.
module t_intersection_phase_scheduler #(
    parameter int TICK_DIV = 50000000,
    parameter int MAIN_MIN = 20,
    parameter int SIDE_MIN = 5,
    parameter int SIDE_MAX = 15,
    parameter int YELLOW   = 3,
    parameter int ALL_RED  = 1,
    parameter int PED_WALK = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       side_sensor,
    input  logic       ped_button,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       ped_walk,
    output logic       ped_dont_walk,
    output logic [2:0] phase
);

    localparam logic [2:0] MAIN_GREEN  = 3'd0;
    localparam logic [2:0] MAIN_YELLOW = 3'd1;
    localparam logic [2:0] ALL_RED_A   = 3'd2;
    localparam logic [2:0] SIDE_GREEN  = 3'd3;
    localparam logic [2:0] SIDE_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_B   = 3'd5;

    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX_0 = (MAIN_MIN > SIDE_MAX) ? MAIN_MIN : SIDE_MAX;
    localparam int TMAX_1 = (TMAX_0 > YELLOW) ? TMAX_0 : YELLOW;
    localparam int TMAX_2 = (TMAX_1 > ALL_RED) ? TMAX_1 : ALL_RED;
    localparam int TMAX   = (TMAX_2 > PED_WALK) ? TMAX_2 : PED_WALK;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int WALK_T = (PED_WALK > SIDE_MIN) ? PED_WALK : SIDE_MIN;

    localparam logic [PW-1:0] C_DIV_M1      = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] C_MAIN_MIN_M1 = TW'(MAIN_MIN - 1);
    localparam logic [TW-1:0] C_SIDE_MIN_M1 = TW'(SIDE_MIN - 1);
    localparam logic [TW-1:0] C_WALK_T_M1   = TW'(WALK_T - 1);
    localparam logic [TW-1:0] C_SIDE_MAX_M1 = TW'(SIDE_MAX - 1);
    localparam logic [TW-1:0] C_YELLOW_M1   = TW'(YELLOW - 1);
    localparam logic [TW-1:0] C_ALL_RED_M1  = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] C_PED_WALK    = TW'(PED_WALK);
    localparam logic [TW-1:0] C_TMAX        = TW'(TMAX);

    logic [2:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_timer;
    logic          r_side_pend;
    logic          r_ped_pend;
    logic          r_walk_grant;
    logic          r_main_red, r_main_yellow, r_main_green;
    logic          r_side_red, r_side_yellow, r_side_green;
    logic          r_ped_walk;

    logic          w_tick;
    logic [2:0]    w_next_state;
    logic          w_state_chg;
    logic          w_enter_side;
    logic [TW-1:0] w_tmin_m1;
    logic [TW-1:0] w_timer_nxt;
    logic          w_walk_grant_nxt;
    logic          w_ped_walk_nxt;
    logic [5:0]    w_lamps_nxt;

    assign w_tick    = (r_presc == C_DIV_M1);
    assign w_tmin_m1 = r_walk_grant ? C_WALK_T_M1 : C_SIDE_MIN_M1;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MAIN_GREEN:  if (w_tick && (r_timer >= C_MAIN_MIN_M1) && (r_side_pend || r_ped_pend))
                             w_next_state = MAIN_YELLOW;
            MAIN_YELLOW: if (w_tick && (r_timer >= C_YELLOW_M1))  w_next_state = ALL_RED_A;
            ALL_RED_A:   if (w_tick && (r_timer >= C_ALL_RED_M1)) w_next_state = SIDE_GREEN;
            // Green extends tick by tick while a vehicle is present, capped at SIDE_MAX.
            SIDE_GREEN:  if (w_tick && (((r_timer >= w_tmin_m1) && !side_sensor) || (r_timer >= C_SIDE_MAX_M1)))
                             w_next_state = SIDE_YELLOW;
            SIDE_YELLOW: if (w_tick && (r_timer >= C_YELLOW_M1))  w_next_state = ALL_RED_B;
            ALL_RED_B:   if (w_tick && (r_timer >= C_ALL_RED_M1)) w_next_state = MAIN_GREEN;
            default:     w_next_state = MAIN_YELLOW;
        endcase
    end

    assign w_state_chg      = (w_next_state != r_state);
    assign w_enter_side     = (r_state == ALL_RED_A) && (w_next_state == SIDE_GREEN);
    assign w_walk_grant_nxt = w_enter_side ? r_ped_pend : r_walk_grant;

    always_comb begin
        w_timer_nxt = r_timer;
        if (w_state_chg)
            w_timer_nxt = '0;
        else if (w_tick && (r_timer != C_TMAX))
            w_timer_nxt = r_timer + 1'b1;
    end

    assign w_ped_walk_nxt = (w_next_state == SIDE_GREEN) && w_walk_grant_nxt && (w_timer_nxt < C_PED_WALK);

    // {main_red, main_yellow, main_green, side_red, side_yellow, side_green}
    always_comb begin
        w_lamps_nxt = 6'b100_100;
        case (w_next_state)
            MAIN_GREEN:  w_lamps_nxt = 6'b001_100;
            MAIN_YELLOW: w_lamps_nxt = 6'b010_100;
            SIDE_GREEN:  w_lamps_nxt = 6'b100_001;
            SIDE_YELLOW: w_lamps_nxt = 6'b100_010;
            default:     w_lamps_nxt = 6'b100_100;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= MAIN_GREEN;
            r_presc       <= '0;
            r_timer       <= '0;
            r_side_pend   <= 1'b0;
            r_ped_pend    <= 1'b0;
            r_walk_grant  <= 1'b0;
            r_main_red    <= 1'b0;
            r_main_yellow <= 1'b0;
            r_main_green  <= 1'b1;
            r_side_red    <= 1'b1;
            r_side_yellow <= 1'b0;
            r_side_green  <= 1'b0;
            r_ped_walk    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_timer      <= w_timer_nxt;
            r_walk_grant <= w_walk_grant_nxt;
            if (w_state_chg || w_tick)
                r_presc <= '0;
            else
                r_presc <= r_presc + 1'b1;
            // Sensor activity during side green only extends that green.
            if (w_enter_side)
                r_side_pend <= 1'b0;
            else if (side_sensor && (r_state != SIDE_GREEN))
                r_side_pend <= 1'b1;
            // A press on the serving edge stays pending for the next cycle.
            if (ped_button)
                r_ped_pend <= 1'b1;
            else if (w_enter_side)
                r_ped_pend <= 1'b0;
            {r_main_red, r_main_yellow, r_main_green,
             r_side_red, r_side_yellow, r_side_green} <= w_lamps_nxt;
            r_ped_walk <= w_ped_walk_nxt;
        end
    end

    assign main_red      = r_main_red;
    assign main_yellow   = r_main_yellow;
    assign main_green    = r_main_green;
    assign side_red      = r_side_red;
    assign side_yellow   = r_side_yellow;
    assign side_green    = r_side_green;
    assign ped_walk      = r_ped_walk;
    assign ped_dont_walk = ~r_ped_walk;
    assign phase         = r_state;

endmodule

// File: tb/tb_t_intersection_phase_scheduler.sv
// Directed bench for the T-intersection scheduler with a short tick (4 cycles) so every phase is a few ticks.
module tb_t_intersection_phase_scheduler;

    logic       clk;
    logic       reset_n;
    logic       side_sensor;
    logic       ped_button;
    logic       main_red, main_yellow, main_green;
    logic       side_red, side_yellow, side_green;
    logic       ped_walk, ped_dont_walk;
    logic [2:0] phase;
    logic [7:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    t_intersection_phase_scheduler #(
        .TICK_DIV (4),
        .MAIN_MIN (4),
        .SIDE_MIN (3),
        .SIDE_MAX (6),
        .YELLOW   (2),
        .ALL_RED  (1),
        .PED_WALK (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .side_sensor   (side_sensor),
        .ped_button    (ped_button),
        .main_red      (main_red),
        .main_yellow   (main_yellow),
        .main_green    (main_green),
        .side_red      (side_red),
        .side_yellow   (side_yellow),
        .side_green    (side_green),
        .ped_walk      (ped_walk),
        .ped_dont_walk (ped_dont_walk),
        .phase         (phase)
    );

    assign outs = {main_red, main_yellow, main_green, side_red, side_yellow, side_green,
                   ped_walk, ped_dont_walk};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] exp_out(input logic [2:0] ph, input logic walk);
        logic [5:0] l;
        case (ph)
            3'd0:    l = 6'b001_100;
            3'd1:    l = 6'b010_100;
            3'd3:    l = 6'b100_001;
            3'd4:    l = 6'b100_010;
            default: l = 6'b100_100;
        endcase
        return {l, walk, ~walk};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts cycles spent in phase ph from now, checking lamps on each one.
    task automatic run_phase(input string tag, input logic [2:0] ph, input logic walk, input int exp_len);
        int n = 0;
        int good = 0;
        check({tag, "/phase"}, 32'(phase), 32'(ph));
        while ((phase === ph) && (n < 400)) begin
            n++;
            if (outs === exp_out(ph, walk)) good++;
            @(negedge clk);
        end
        check({tag, "/len"}, n, exp_len);
        check({tag, "/lamps"}, good, n);
    endtask

    task automatic hold_phase(input string tag, input logic [2:0] ph, input logic walk, input int ncyc);
        int good = 0;
        for (int i = 0; i < ncyc; i++) begin
            if ((phase === ph) && (outs === exp_out(ph, walk))) good++;
            @(negedge clk);
        end
        check({tag, "/hold"}, good, ncyc);
    endtask

    // Leaves the bench at the release edge, i.e. cycle 0 of MAIN_GREEN.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset_n     = 1'b0;
        side_sensor = 1'b0;
        ped_button  = 1'b0;
        @(negedge clk);
        check({tag, "/rst_phase"}, 32'(phase), 32'd0);
        check({tag, "/rst_outs"}, 32'(outs), 32'(exp_out(3'd0, 1'b0)));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        side_sensor = 1'b0;
        ped_button  = 1'b0;

        // 1: idle main green
        apply_reset("t1");
        hold_phase("t1_idle", 3'd0, 1'b0, 200);

        // 2: single sensor pulse at cycle 2; 3 cycles of main green already elapsed
        apply_reset("t2");
        repeat (2) @(negedge clk);
        side_sensor = 1'b1;
        @(negedge clk);
        side_sensor = 1'b0;
        run_phase("t2_mg",  3'd0, 1'b0, 13);
        run_phase("t2_my",  3'd1, 1'b0, 8);
        run_phase("t2_ara", 3'd2, 1'b0, 4);
        run_phase("t2_sg",  3'd3, 1'b0, 12);
        run_phase("t2_sy",  3'd4, 1'b0, 8);
        run_phase("t2_arb", 3'd5, 1'b0, 4);
        hold_phase("t2_idle", 3'd0, 1'b0, 60);

        // 3: sensor held high -> side green runs to max
        apply_reset("t3");
        side_sensor = 1'b1;
        run_phase("t3_mg",  3'd0, 1'b0, 16);
        run_phase("t3_my",  3'd1, 1'b0, 8);
        run_phase("t3_ara", 3'd2, 1'b0, 4);
        run_phase("t3_sg",  3'd3, 1'b0, 24);
        run_phase("t3_sy",  3'd4, 1'b0, 8);
        run_phase("t3_arb", 3'd5, 1'b0, 4);
        run_phase("t3_mg2", 3'd0, 1'b0, 16);
        side_sensor = 1'b0;
        run_phase("t3_my2",  3'd1, 1'b0, 8);
        run_phase("t3_ara2", 3'd2, 1'b0, 4);
        run_phase("t3_sg2",  3'd3, 1'b0, 12);
        run_phase("t3_sy2",  3'd4, 1'b0, 8);
        run_phase("t3_arb2", 3'd5, 1'b0, 4);
        hold_phase("t3_idle", 3'd0, 1'b0, 40);

        // 4: pedestrian only -> walk interval sets the side green
        apply_reset("t4");
        ped_button = 1'b1;
        @(negedge clk);
        ped_button = 1'b0;
        run_phase("t4_mg",  3'd0, 1'b0, 15);
        run_phase("t4_my",  3'd1, 1'b0, 8);
        run_phase("t4_ara", 3'd2, 1'b0, 4);
        run_phase("t4_sg",  3'd3, 1'b1, 20);
        run_phase("t4_sy",  3'd4, 1'b0, 8);
        run_phase("t4_arb", 3'd5, 1'b0, 4);
        hold_phase("t4_idle", 3'd0, 1'b0, 40);

        // 5: second press during walk is served by a later cycle
        apply_reset("t5");
        ped_button = 1'b1;
        @(negedge clk);
        ped_button = 1'b0;
        run_phase("t5_mg",  3'd0, 1'b0, 15);
        run_phase("t5_my",  3'd1, 1'b0, 8);
        run_phase("t5_ara", 3'd2, 1'b0, 4);
        hold_phase("t5_sg_a", 3'd3, 1'b1, 8);
        ped_button = 1'b1;
        run_phase("t5_sg_b", 3'd3, 1'b1, 12);
        ped_button = 1'b0;
        run_phase("t5_sy",   3'd4, 1'b0, 8);
        run_phase("t5_arb",  3'd5, 1'b0, 4);
        run_phase("t5_mg2",  3'd0, 1'b0, 16);
        run_phase("t5_my2",  3'd1, 1'b0, 8);
        run_phase("t5_ara2", 3'd2, 1'b0, 4);
        run_phase("t5_sg2",  3'd3, 1'b1, 20);
        run_phase("t5_sy2",  3'd4, 1'b0, 8);
        run_phase("t5_arb2", 3'd5, 1'b0, 4);
        hold_phase("t5_idle", 3'd0, 1'b0, 40);

        // 6: reset during main yellow discards the pending walk request
        apply_reset("t6");
        ped_button = 1'b1;
        @(negedge clk);
        ped_button = 1'b0;
        run_phase("t6_mg", 3'd0, 1'b0, 15);
        hold_phase("t6_my", 3'd1, 1'b0, 3);
        reset_n = 1'b0;
        #1;
        check("t6_async_phase", 32'(phase), 32'd0);
        check("t6_async_outs", 32'(outs), 32'(exp_out(3'd0, 1'b0)));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        hold_phase("t6_idle", 3'd0, 1'b0, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
